wb_regfile: RTL
===============

# wb_regfile

Writeback-end consumer of the WB pipeline latch: takes the latched `reg_write_reg` / `memto_reg_reg` controls plus the MEM-stage data, selects the writeback value, and commits it into a 32-entry general-purpose register file. Provides the two decode-stage read ports with same-cycle write-through bypass, so a value written back in cycle N is visible to decode in cycle N. It also keeps a running count of committed writes for bench and debug use.

## Interface
- `DATA_WIDTH`, 32, register and datapath width
- `ADDR_WIDTH`, 5, register index width (2^ADDR_WIDTH entries)
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `reg_write_reg`  in  1  latched write enable from WB latch
- `memto_reg_reg`  in  1  latched select from WB latch: 1 = memory data, 0 = ALU result
- `mem_data`  in  DATA_WIDTH  load data from data memory
- `alu_result`  in  DATA_WIDTH  ALU result carried to WB
- `write_addr`  in  ADDR_WIDTH  destination register index
- `rs_addr`  in  ADDR_WIDTH  read port A index
- `rt_addr`  in  ADDR_WIDTH  read port B index
- `rs_data`  out  DATA_WIDTH  read port A data
- `rt_data`  out  DATA_WIDTH  read port B data
- `wb_data`  out  DATA_WIDTH  selected writeback value, for forwarding units
- `wb_valid`  out  1  a committing write is present this cycle
- `wb_count`  out  32  number of committed writes since reset

## Operation
- Writeback mux: `wb_data` = `memto_reg_reg` ? `mem_data` : `alu_result`. Purely combinational, valid regardless of `reg_write_reg`.
- Commit condition: `wb_valid` = `reg_write_reg` && (`write_addr` != 0) && !`reset`.
- On rising `clk` with `wb_valid` = 1: `regs[write_addr]` <= `wb_data`; `wb_count` <= `wb_count` + 1.
- Register 0 is hardwired zero: writes to index 0 are discarded, do not count, never assert `wb_valid`; reads of index 0 return 0.
- Read ports are combinational with write-first bypass. For each port P in {rs, rt}:
  - P_addr == 0 -> 0
  - else `wb_valid` && P_addr == `write_addr` -> `wb_data`
  - else `regs[P_addr]`
- Both ports may address the same register and may both hit the bypass simultaneously; both return `wb_data`.
- `wb_count` wraps modulo 2^32 (0xFFFFFFFF + 1 -> 0); no saturation, no flag.
- No state machine: storage is the register array plus the counter.

## Timing
- Reset (async assert): all registers, and `wb_count`, are 0 immediately without waiting for a clock edge. While `reset` is high, `wb_valid` = 0, no write commits, and `rs_data`/`rt_data` read 0 (array is zero and bypass is disabled). `wb_data` still follows the mux.
- Reset deassert: the first write commits on the first rising edge with `reset` low.
- Reset asserted mid-cycle with a pending write: the write is lost. The array stays 0 and the counter stays 0.
- Write latency: 1 edge to the array. Read-after-write in the same cycle sees new data via bypass (0 cycles effective). In the next cycle the data comes from the array.
- Read latency: combinational, 0 cycles.
- Inputs must be stable before the rising edge. The inputs come from the WB latch, which itself updates on `clk`.
- Back-to-back writes to the same index: the last write wins. Each write increments `wb_count`.

## Test plan
- Reset: drive `reset`=1 mid-cycle after several writes. Required: all reads and `wb_count` become 0 before the next edge, and `wb_valid`=0.
- ALU writeback: `reg_write_reg`=1, `memto_reg_reg`=0, `alu_result`=0x0000_00A5, `write_addr`=3, `rs_addr`=3. Required: `rs_data`=0xA5 in the same cycle via bypass. After the edge, `regs[3]`=0xA5 with `reg_write_reg`=0, and `wb_count`=1.
- Memory writeback plus dual read: `memto_reg_reg`=1, `mem_data`=0xDEAD_BEEF, `alu_result`=0x1234, `write_addr`=7, `rs_addr`=`rt_addr`=7. Required: both ports = 0xDEADBEEF. After the edge, the array holds 0xDEADBEEF.
- r0 protection: write 0xFFFF_FFFF to index 0 with `reg_write_reg`=1. Required: `wb_valid`=0, `rs_data` for index 0 = 0, and `wb_count` unchanged.
- Write disabled: `reg_write_reg`=0, `write_addr`=5, `alu_result`=0x55. Required: `regs[5]` keeps its prior value (0 after reset), and there is no bypass to `rs_addr`=5.
- Counter wrap: force `wb_count` to 0xFFFF_FFFF, then commit one write. Required: `wb_count`=0.

Source files
------------

// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Purpose  : Writeback mux, 32-entry register file with write-first bypass,
//            and a count of committed writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_reg,
    input  logic                  memto_reg_reg,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_valid,
    output logic [31:0]           wb_count
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [31:0]           wb_count_q;
    logic [31:0]           wb_count_d;

    assign wb_data    = memto_reg_reg ? mem_data : alu_result;
    // Gating with reset keeps the bypass off while the array is held clear.
    assign wb_valid   = reg_write_reg && (write_addr != '0) && !reset;
    assign wb_count_d = wb_count_q + 32'd1;
    assign wb_count   = wb_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else if (wb_valid) begin
            regs_q[write_addr] <= wb_data;
            wb_count_q         <= wb_count_d;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_valid && (rs_addr == write_addr)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_valid && (rt_addr == write_addr)) begin
            rt_data = wb_data;
        end
    end

endmodule

`default_nettype wire
